// File: rtl/counter_arbiter_if.sv
// Request/response bundle between N requesters and the counter arbiter.
// master = requester side, slave = arbiter side.
interface counter_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_op;
    logic [4*N-1:0] req_delta;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [7:0]     rsp_data;
    logic           rsp_sat;

    modport master (
        output req_valid, req_op, req_delta, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat
    );

    modport slave (
        input  req_valid, req_op, req_delta, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin sequencer sharing one 8-bit step counter among N requesters.
// Each accepted op takes IDLE -> ISSUE -> RESP; the counter is held (delta 0) outside ISSUE.
module counter_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              reset,
    counter_arbiter_if.slave  bus,
    output logic              cnt_preload,
    output logic              cnt_up_dn,
    output logic [3:0]        cnt_delta,
    output logic [7:0]        cnt_pl_data,
    input  logic [7:0]        cnt_qout
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [1:0] OP_UP = 2'b00;
    localparam logic [1:0] OP_DN = 2'b01;
    localparam logic [1:0] OP_PL = 2'b10;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_q;
    logic [1:0]     op_q;
    logic [3:0]     delta_q;
    logic [7:0]     data_q;
    logic           rsp_valid_q;
    logic           rsp_sat_q;

    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [1:0]     sel_op;
    logic [3:0]     sel_delta;
    logic [7:0]     sel_data;
    logic [IDW-1:0] next_ptr;

    // A step is refused when it would leave 0..255; 9-bit compare so nothing wraps.
    function automatic logic step_refused(input logic [1:0] op, input logic [3:0] delta,
                                          input logic [7:0] q);
        logic [8:0] q9;
        logic [8:0] d9;
        q9 = {1'b0, q};
        d9 = {5'b0, delta};
        if (delta == 4'd0)
            return 1'b0;
        case (op)
            OP_UP:   return q9 > (9'd255 - d9);
            OP_DN:   return q9 < d9;
            default: return 1'b0;
        endcase
    endfunction

    // Search ptr, ptr+1, ... mod N; descending k lets the nearest requester win.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && (((int'(ptr) + k) % N) == i)) begin
                    grant_found = 1'b1;
                    grant_id    = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_delta = '0;
        sel_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_op    = bus.req_op[2*i +: 2];
                sel_delta = bus.req_delta[4*i +: 4];
                sel_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < N; i++)
            bus.req_ready[i] = !reset && (state == IDLE) && grant_found && (grant_id == IDW'(i));
    end

    assign next_ptr = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            id_q        <= '0;
            op_q        <= '0;
            delta_q     <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sat_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        id_q    <= grant_id;
                        op_q    <= sel_op;
                        delta_q <= sel_delta;
                        data_q  <= sel_data;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // cnt_qout is still the pre-step value here.
                    rsp_sat_q   <= step_refused(op_q, delta_q, cnt_qout);
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sat   = rsp_sat_q;
    // The counter is frozen outside ISSUE, so its output is stable for the whole RESP.
    assign bus.rsp_data  = (state == RESP) ? cnt_qout : 8'd0;

    always_comb begin
        cnt_preload = 1'b0;
        cnt_up_dn   = 1'b0;
        cnt_delta   = 4'd0;
        cnt_pl_data = 8'd0;
        if (state == ISSUE) begin
            case (op_q)
                OP_UP: begin
                    cnt_up_dn = 1'b1;
                    cnt_delta = delta_q;
                end
                OP_DN:   cnt_delta = delta_q;
                OP_PL: begin
                    cnt_preload = 1'b1;
                    cnt_pl_data = data_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: behavioural step counter, transaction-level reference
// model, directed scenarios followed by randomized traffic with occasional resets.
module tb_counter_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int OPW = 2 * N;
    localparam int DW  = 4 * N;
    localparam int PW  = 8 * N;
    localparam int UP = 0, DN = 1, PL = 2, RD = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    counter_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    logic       cnt_preload;
    logic       cnt_up_dn;
    logic [3:0] cnt_delta;
    logic [7:0] cnt_pl_data;
    logic [7:0] cnt_qout;

    counter_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cnt_preload (cnt_preload),
        .cnt_up_dn   (cnt_up_dn),
        .cnt_delta   (cnt_delta),
        .cnt_pl_data (cnt_pl_data),
        .cnt_qout    (cnt_qout)
    );

    // Step counter: applies its step every clock, refuses steps that leave 0..255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_qout <= 8'd0;
        else if (cnt_preload)
            cnt_qout <= cnt_pl_data;
        else if (cnt_up_dn) begin
            if ({1'b0, cnt_qout} + {5'b0, cnt_delta} <= 9'd255)
                cnt_qout <= cnt_qout + cnt_delta;
        end else if (cnt_qout >= {4'b0, cnt_delta})
            cnt_qout <= cnt_qout - cnt_delta;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: one outstanding transaction at most.
    bit     outstanding = 0;
    int     acc_cyc, exp_id, exp_op, exp_delta, exp_pl, exp_data;
    bit     exp_sat;
    int     model_ptr = 0;
    int     model_cnt = 0;
    int     rsp_count = 0;
    int     last_id, last_data, last_lat, last_rsp_cyc;
    bit     last_sat;
    logic [N-1:0] rearm      = '0;
    logic [N-1:0] clear_mask = '0;
    int     grant_ids[$];
    int     grant_cycs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (((v >> idx) & N'(1)) != '0)
                return idx;
        end
        return -1;
    endfunction

    task automatic monitor();
        int pick;
        bit exp_rv;
        logic [N-1:0]   exp_rdy;
        logic [13:0]    exp_ctl;
        logic [OPW-1:0] t_op;
        logic [DW-1:0]  t_d;
        logic [PW-1:0]  t_p;
        cyc++;
        if (reset) begin
            check("rst_req_ready", 32'(bus.req_ready), 0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            check("rst_rsp_id", 32'(bus.rsp_id), 0);
            check("rst_rsp_data", 32'(bus.rsp_data), 0);
            check("rst_rsp_sat", 32'(bus.rsp_sat), 0);
            check("rst_cnt_ctl", 32'({cnt_preload, cnt_up_dn, cnt_delta, cnt_pl_data}), 0);
            outstanding = 0;
            model_ptr   = 0;
            model_cnt   = 0;
            return;
        end
        exp_ctl = '0;
        if (outstanding && cyc == acc_cyc + 1)
            exp_ctl = {exp_op == PL, exp_op == UP, (exp_op < 2) ? 4'(exp_delta) : 4'd0,
                       (exp_op == PL) ? 8'(exp_pl) : 8'd0};
        check("cnt_ctl", 32'({cnt_preload, cnt_up_dn, cnt_delta, cnt_pl_data}), 32'(exp_ctl));
        exp_rv = outstanding && (cyc >= acc_cyc + 2);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            check("rsp_id", 32'(bus.rsp_id), exp_id);
            check("rsp_data", 32'(bus.rsp_data), exp_data);
            check("rsp_sat", 32'(bus.rsp_sat), 32'(exp_sat));
        end
        if (!outstanding)
            check("cnt_hold", 32'(cnt_qout), model_cnt);
        pick    = outstanding ? -1 : rr_pick(model_ptr, bus.req_valid);
        exp_rdy = (pick < 0) ? '0 : (N'(1) << pick);
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (exp_rv && bus.rsp_valid && bus.rsp_ready) begin
            rsp_count++;
            last_id      = int'(bus.rsp_id);
            last_data    = int'(bus.rsp_data);
            last_sat     = bus.rsp_sat;
            last_lat     = cyc - acc_cyc;
            last_rsp_cyc = cyc;
            model_ptr    = (exp_id + 1) % N;
            outstanding  = 0;
        end
        if (pick >= 0) begin
            t_op      = bus.req_op >> (2 * pick);
            t_d       = bus.req_delta >> (4 * pick);
            t_p       = bus.req_data >> (8 * pick);
            exp_op    = int'(t_op[1:0]);
            exp_delta = int'(t_d[3:0]);
            exp_pl    = int'(t_p[7:0]);
            exp_sat   = 0;
            case (exp_op)
                UP: if (model_cnt + exp_delta > 255) exp_sat = (exp_delta != 0);
                    else model_cnt = model_cnt + exp_delta;
                DN: if (model_cnt - exp_delta < 0) exp_sat = (exp_delta != 0);
                    else model_cnt = model_cnt - exp_delta;
                PL: model_cnt = exp_pl;
                default: ;
            endcase
            exp_data    = model_cnt;
            exp_id      = pick;
            outstanding = 1;
            acc_cyc     = cyc;
            clear_mask  = clear_mask | (N'(1) << pick);
            grant_ids.push_back(pick);
            grant_cycs.push_back(cyc);
        end
    endtask

    // Sample at the falling edge; return just after the next rising edge to drive.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~(clear_mask & ~rearm);
        clear_mask    = '0;
    endtask

    task automatic set_req(input int i, input int op, input int delta, input int data);
        bus.req_valid = bus.req_valid | (N'(1) << i);
        bus.req_op    = (bus.req_op & ~(OPW'(3) << (2 * i))) | (OPW'(op) << (2 * i));
        bus.req_delta = (bus.req_delta & ~(DW'(15) << (4 * i))) | (DW'(delta) << (4 * i));
        bus.req_data  = (bus.req_data & ~(PW'(255) << (8 * i))) | (PW'(data) << (8 * i));
    endtask

    task automatic run_op(input string tag, input int i, input int op, input int delta,
                          input int data);
        int rc;
        rc = rsp_count;
        set_req(i, op, delta, data);
        for (int k = 0; k < 30 && rsp_count == rc; k++)
            cycle();
        check({tag, "_done"}, rsp_count - rc, 1);
    endtask

    task automatic wait_grants(input string tag, input int target);
        for (int k = 0; k < 60 && grant_ids.size() < target; k++)
            cycle();
        check({tag, "_grant"}, grant_ids.size() >= target, 1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60 && (outstanding || bus.req_valid != '0); k++)
            cycle();
        check({tag, "_drain"}, outstanding, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_delta = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (3) cycle();

        // Step up from 0x10 by 5.
        run_op("pl10", 1, PL, 0, 8'h10);
        run_op("up5", 0, UP, 5, 0);
        check("up5_data", last_data, 32'h15);
        check("up5_sat", 32'(last_sat), 0);
        check("up5_id", last_id, 0);
        check("up5_latency", last_lat, 2);

        // Range limits.
        run_op("plFA", 1, PL, 0, 8'hFA);
        check("plFA_data", last_data, 32'hFA);
        check("plFA_sat", 32'(last_sat), 0);
        run_op("up8", 1, UP, 8, 0);
        check("up8_data", last_data, 32'hFA);
        check("up8_sat", 32'(last_sat), 1);
        run_op("pl03", 2, PL, 0, 8'h03);
        run_op("dn4", 2, DN, 4, 0);
        check("dn4_data", last_data, 32'h03);
        check("dn4_sat", 32'(last_sat), 1);

        // Reset in the middle of a RESP that is being held off.
        bus.rsp_ready = 1'b0;
        set_req(0, UP, 1, 0);
        repeat (3) cycle();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (4) cycle();
        check("post_rst_cnt", 32'(cnt_qout), 0);
        check("post_rst_delta", 32'(cnt_delta), 0);

        // Round-robin with all four requesters holding reads.
        g0    = grant_ids.size();
        rearm = '1;
        for (int i = 0; i < N; i++) set_req(i, RD, 0, 0);
        wait_grants("rr", g0 + 6);
        rearm         = '0;
        bus.req_valid = '0;
        drain("rr");
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_order%0d", k), grant_ids[g0 + k], k % N);
            if (k > 0)
                check($sformatf("rr_gap%0d", k), grant_cycs[g0 + k] - grant_cycs[g0 + k - 1], 3);
        end

        // Backpressure with req 2 pending.
        g0 = grant_ids.size();
        bus.rsp_ready = 1'b0;
        set_req(1, RD, 0, 0);
        wait_grants("bp1", g0 + 1);
        set_req(2, RD, 0, 0);
        for (int k = 0; k < 10 && !bus.rsp_valid; k++)
            cycle();
        check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
        repeat (4) cycle();
        check("bp_no_grant", grant_ids.size(), g0 + 1);
        bus.rsp_ready = 1'b1;
        cycle();
        cycle();
        check("bp_grant_id", grant_ids[grant_ids.size() - 1], 2);
        check("bp_grant_gap", grant_cycs[grant_ids.size() - 1] - last_rsp_cyc, 1);
        drain("bp");

        // Reset during ISSUE of a preload: no response, ptr back to 0.
        g0 = grant_ids.size();
        set_req(2, PL, 0, 8'h80);
        wait_grants("mid", g0 + 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        g0 = rsp_count;
        set_req(3, RD, 0, 0);
        wait_grants("mid3", grant_ids.size() + 1);
        check("mid_first_id", grant_ids[grant_ids.size() - 1], 3);
        drain("mid");
        check("mid_rsp_count", rsp_count - g0, 1);
        check("mid_rsp_data", last_data, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (((bus.req_valid >> i) & N'(1)) == '0) begin
                    if ($urandom % 4 == 0)
                        set_req(i, int'($urandom % 4), ($urandom % 3 == 0) ? 0 : int'($urandom % 16),
                                ($urandom % 2 == 0) ? int'($urandom % 256)
                                                    : (($urandom % 2 == 0) ? int'($urandom % 16)
                                                                           : 240 + int'($urandom % 16)));
                end else if ($urandom % 50 == 0)
                    bus.req_valid = bus.req_valid & ~(N'(1) << i);
            end
            bus.rsp_ready = ($urandom % 3) != 0;
            reset         = ($urandom % 400) == 0;
        end
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin arbiter and sequencer that shares one 8-bit step counter (preload, up/down by 4-bit delta, step refused at range limits) among N requesters. It sits in front of the counter, owns all of the counter's control inputs, and serialises step, preload and read operations. Each accepted operation returns the post-operation counter value, a refused-step flag and the requester ID. The counter has no enable and applies its step on every clock, so this block holds it by driving delta = 0 whenever no operation is being issued.

## Interface
- N, default 4: number of requesters (2..8).
- IDW, default 2: width of requester ID; must satisfy 2^IDW >= N.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  N  per-requester request valid.
- req_op  in  2N  per-requester opcode, slice [2i+1:2i]: 00 step up, 01 step down, 10 preload, 11 read.
- req_delta  in  4N  per-requester step size, slice [4i+3:4i].
- req_data  in  8N  per-requester preload value, slice [8i+7:8i].
- req_ready  out  N  one-cycle accept pulse, at most one bit set.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_data  out  8  counter value after the operation.
- rsp_sat  out  1  step was refused at a range limit.
- cnt_preload  out  1  counter preload.
- cnt_up_dn  out  1  counter direction; 1 = up.
- cnt_delta  out  4  counter step.
- cnt_pl_data  out  8  counter preload value.
- cnt_qout  in  8  counter current value.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req_valid bit is set, select winner i by round-robin starting at pointer ptr, searching ptr, ptr+1, ... modulo N.
  - Latch op, delta and data of i.
  - Pulse req_ready[i] for that cycle.
  - Go to ISSUE.
- ISSUE: drive the counter from latched values for exactly one cycle, then go to RESP.
  - Step up: cnt_up_dn=1, cnt_delta=delta, cnt_preload=0.
  - Step down: cnt_up_dn=0, cnt_delta=delta, cnt_preload=0.
  - Preload: cnt_preload=1, cnt_pl_data=data.
  - Read: cnt_delta=0, cnt_preload=0.
- Refused-step flag, computed in ISSUE from cnt_qout and latched into rsp_sat:
  - Up: sat = (cnt_qout > 255 - delta).
  - Down: sat = (cnt_qout < delta).
  - Preload, read, or delta = 0: sat = 0.
- RESP: rsp_valid=1, rsp_data=cnt_qout, rsp_id=i, rsp_sat latched.
  - Hold all response outputs stable until rsp_valid && rsp_ready.
  - On that cycle: ptr <= (i+1) mod N, go to IDLE.
- Idle counter drive: outside ISSUE, hold cnt_preload=0, cnt_delta=0, cnt_up_dn=0 and cnt_pl_data=0, so the counter holds its value.
- Arithmetic: limit comparisons use 9-bit unsigned math, with no wrap-around. The counter never wraps; a refused step leaves its value unchanged.
- Request rules:
  - Requesters hold req_valid and payload stable until req_ready.
  - Payload is sampled only in the accept cycle.
  - req_valid dropping before accept is legal; that request is simply not granted.
  - A requester may re-request in the cycle after its accept; round-robin prevents it from starving the others.
- Reset, at any time including mid-ISSUE or mid-RESP:
  - State -> IDLE, ptr=0.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat and all cnt_* outputs.
  - Any in-flight operation is dropped with no response.

## Timing
- Accept cycle T (IDLE with a valid request): req_ready pulses during T.
- Cycle T+1 (ISSUE): counter controls are active. The counter updates at the rising edge ending T+1.
- Cycle T+2 (RESP): rsp_valid=1, and rsp_data reflects the new value.
- Minimum cost is 3 cycles per operation, with rsp_ready held high.
- Each cycle of rsp_ready low adds one cycle and blocks new accepts.
- No request is accepted while in ISSUE or RESP.
- req_ready is a Moore output of IDLE qualified by the current req_valid.
- All other outputs are registered or decoded from state.

## Test plan
- Reset: assert reset mid-stream. Required: all outputs 0 and state IDLE. After release with no requests, cnt_delta stays 0 and cnt_qout stays 0.
- Step up: counter at 0x10, req 0 steps up by 5 with rsp_ready=1. Required: req_ready[0] at T, cnt_delta=5 at T+1, rsp_data=0x15, rsp_sat=0, rsp_id=0 at T+2.
- Range limits:
  - Preload 0xFA from req 1, then step up by 8. Required: rsp_data 0xFA then 0xFA, with rsp_sat 0 then 1.
  - Preload 0x03, then step down by 4. Required: rsp_data 0x03 with rsp_sat=1.
- Round-robin: all four req_valid held high with reads. Required: grant order 0, 1, 2, 3, 0, 1, accepts spaced exactly 3 cycles apart.
- Backpressure: rsp_ready low for 4 cycles in RESP with req 2 pending. Required: rsp_valid, rsp_data and rsp_id stable; no req_ready pulse until the cycle after the rsp handshake.
- Reset mid-ISSUE: reset during ISSUE of a preload of 0x80. Required: no response, ptr=0; the next request from req 3 is granted first.
